// File: rtl/dual_core_mem_arbiter.sv
// Two-core shared-memory arbiter: round-robin grant, LL/SC reservation tracking with write snooping.
// Optional grant watchdog enabled by defining ARB_TIMEOUT_EN.
module dual_core_mem_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_P0,
    input  logic        req_P1,
    input  logic        mw_P0,
    input  logic        mw_P1,
    input  logic [31:0] MAR_P0,
    input  logic [31:0] MAR_P1,
    input  logic        atomic_inst_P0,
    input  logic        atomic_inst_P1,
    input  logic [1:0]  instr_type_P0,
    input  logic [1:0]  instr_type_P1,
    input  logic        trigger_P0,
    input  logic        trigger_P1,
    input  logic        P0_mem_complete,
    input  logic        P1_mem_complete,
    output logic        P0_pass,
    output logic        P1_pass,
    output logic        P0_success,
    output logic        P1_success,
    output logic [1:0]  owner,
    output logic [1:0]  RSV_valid
);

    // state  | meaning
    // IDLE   | no grant outstanding
    // OWN_P0 | core 0 holds the memory grant
    // OWN_P1 | core 1 holds the memory grant
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        OWN_P0 = 2'b01,
        OWN_P1 = 2'b10
    } state_t;

    state_t      state, state_nxt;
    logic        last_owner, last_owner_nxt;   // 0 = P0, 1 = P1
    logic [31:0] rsv_adr_0, rsv_adr_1;
    logic        timeout;

    logic        trig_0, trig_1;
    logic        ll_0, ll_1, sc_0, sc_1;
    logic        sc_ok_0, sc_ok_1;
    logic        wr_0, wr_1;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] wd_cnt;

    always_ff @(posedge clk) begin
        if (reset)
            wd_cnt <= 8'd0;
        else if (state == IDLE)
            wd_cnt <= 8'd0;
        else
            wd_cnt <= wd_cnt + 8'd1;
    end

    assign timeout = (state != IDLE) && (wd_cnt == 8'hff);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_owner <= 1'b1;
        end else begin
            state      <= state_nxt;
            last_owner <= last_owner_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        last_owner_nxt = last_owner;
        case (state)
            IDLE: begin
                if (req_P0 && req_P1)
                    state_nxt = last_owner ? OWN_P0 : OWN_P1;
                else if (req_P0)
                    state_nxt = OWN_P0;
                else if (req_P1)
                    state_nxt = OWN_P1;
            end
            OWN_P0: begin
                if (P0_mem_complete || timeout) begin
                    state_nxt      = IDLE;
                    last_owner_nxt = 1'b0;
                end
            end
            OWN_P1: begin
                if (P1_mem_complete || timeout) begin
                    state_nxt      = IDLE;
                    last_owner_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Triggers only count for the core currently holding the grant.
    always_comb begin
        trig_0  = (state == OWN_P0) && trigger_P0;
        trig_1  = (state == OWN_P1) && trigger_P1;
        ll_0    = trig_0 && atomic_inst_P0 && (instr_type_P0 == 2'b01);
        ll_1    = trig_1 && atomic_inst_P1 && (instr_type_P1 == 2'b01);
        sc_0    = trig_0 && atomic_inst_P0 && (instr_type_P0 == 2'b10);
        sc_1    = trig_1 && atomic_inst_P1 && (instr_type_P1 == 2'b10);
        sc_ok_0 = RSV_valid[0] && (rsv_adr_0 == MAR_P0);
        sc_ok_1 = RSV_valid[1] && (rsv_adr_1 == MAR_P1);
        wr_0    = (state == OWN_P0) && P0_mem_complete && mw_P0;
        wr_1    = (state == OWN_P1) && P1_mem_complete && mw_P1;
    end

    // Only one core can own at a time, so own-core and snoop updates never collide.
    always_ff @(posedge clk) begin
        if (reset) begin
            P0_success <= 1'b0;
            P1_success <= 1'b0;
            RSV_valid  <= 2'b00;
            rsv_adr_0  <= 32'd0;
            rsv_adr_1  <= 32'd0;
        end else begin
            if (trig_0)
                P0_success <= sc_0 ? sc_ok_0 : 1'b1;
            if (trig_1)
                P1_success <= sc_1 ? sc_ok_1 : 1'b1;

            if (ll_0) begin
                RSV_valid[0] <= 1'b1;
                rsv_adr_0    <= MAR_P0;
            end else if (sc_0 || (timeout && state == OWN_P0)) begin
                RSV_valid[0] <= 1'b0;
            end
            if (wr_1 && (rsv_adr_0 == MAR_P1))
                RSV_valid[0] <= 1'b0;

            if (ll_1) begin
                RSV_valid[1] <= 1'b1;
                rsv_adr_1    <= MAR_P1;
            end else if (sc_1 || (timeout && state == OWN_P1)) begin
                RSV_valid[1] <= 1'b0;
            end
            if (wr_0 && (rsv_adr_1 == MAR_P0))
                RSV_valid[1] <= 1'b0;
        end
    end

    assign P0_pass = (state == OWN_P0);
    assign P1_pass = (state == OWN_P1);
    assign owner   = state;

endmodule

// File: tb/tb_dual_core_mem_arbiter.sv
// Directed testbench for dual_core_mem_arbiter; timeout scenario compiled only with ARB_TIMEOUT_EN.
module tb_dual_core_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_P0, req_P1, mw_P0, mw_P1;
    logic [31:0] MAR_P0, MAR_P1;
    logic        atomic_inst_P0, atomic_inst_P1;
    logic [1:0]  instr_type_P0, instr_type_P1;
    logic        trigger_P0, trigger_P1;
    logic        P0_mem_complete, P1_mem_complete;
    logic        P0_pass, P1_pass, P0_success, P1_success;
    logic [1:0]  owner, RSV_valid;

    int vectors = 0;
    int miscompares = 0;

    dual_core_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .req_P0(req_P0), .req_P1(req_P1),
        .mw_P0(mw_P0), .mw_P1(mw_P1),
        .MAR_P0(MAR_P0), .MAR_P1(MAR_P1),
        .atomic_inst_P0(atomic_inst_P0), .atomic_inst_P1(atomic_inst_P1),
        .instr_type_P0(instr_type_P0), .instr_type_P1(instr_type_P1),
        .trigger_P0(trigger_P0), .trigger_P1(trigger_P1),
        .P0_mem_complete(P0_mem_complete), .P1_mem_complete(P1_mem_complete),
        .P0_pass(P0_pass), .P1_pass(P1_pass),
        .P0_success(P0_success), .P1_success(P1_success),
        .owner(owner), .RSV_valid(RSV_valid)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        req_P0 = 0; req_P1 = 0; mw_P0 = 0; mw_P1 = 0;
        MAR_P0 = 0; MAR_P1 = 0;
        atomic_inst_P0 = 0; atomic_inst_P1 = 0;
        instr_type_P0 = 0; instr_type_P1 = 0;
        trigger_P0 = 0; trigger_P1 = 0;
        P0_mem_complete = 0; P1_mem_complete = 0;
    endtask

    task automatic do_grant(input int c);
        if (c == 0) req_P0 = 1; else req_P1 = 1;
        tick();
    endtask

    task automatic do_release(input int c, input logic w, input logic [31:0] a);
        if (c == 0) begin P0_mem_complete = 1; mw_P0 = w; MAR_P0 = a; req_P0 = 0; end
        else        begin P1_mem_complete = 1; mw_P1 = w; MAR_P1 = a; req_P1 = 0; end
        tick();
        P0_mem_complete = 0; P1_mem_complete = 0; mw_P0 = 0; mw_P1 = 0;
    endtask

    task automatic do_trig(input int c, input logic at, input logic [1:0] ty, input logic [31:0] a);
        if (c == 0) begin trigger_P0 = 1; atomic_inst_P0 = at; instr_type_P0 = ty; MAR_P0 = a; end
        else        begin trigger_P1 = 1; atomic_inst_P1 = at; instr_type_P1 = ty; MAR_P1 = a; end
        tick();
        trigger_P0 = 0; trigger_P1 = 0; atomic_inst_P0 = 0; atomic_inst_P1 = 0;
    endtask

    task automatic test_reset;
        clear_inputs();
        reset = 1;
        tick(); tick();
        reset = 0;
        vectors++; if (owner !== 2'b00) begin miscompares++; $display("FAIL reset_owner: got %b want 00", owner); end
        vectors++; if ({P0_pass, P1_pass} !== 2'b00) begin miscompares++; $display("FAIL reset_pass: got %b want 00", {P0_pass, P1_pass}); end
        vectors++; if ({P0_success, P1_success} !== 2'b00) begin miscompares++; $display("FAIL reset_success: got %b want 00", {P0_success, P1_success}); end
        vectors++; if (RSV_valid !== 2'b00) begin miscompares++; $display("FAIL reset_rsv: got %b want 00", RSV_valid); end
    endtask

    task automatic test_round_robin;
        req_P0 = 1; req_P1 = 1;
        tick();
        vectors++; if ({P0_pass, P1_pass, owner} !== 4'b1001) begin miscompares++; $display("FAIL rr_first_tie: got %b want 1001", {P0_pass, P1_pass, owner}); end
        req_P0 = 0;
        tick(); tick();
        vectors++; if (P0_pass !== 1'b1) begin miscompares++; $display("FAIL rr_req_drop_hold: got %b want 1", P0_pass); end
        req_P0 = 1;
        P0_mem_complete = 1;
        tick();
        P0_mem_complete = 0;
        vectors++; if ({P0_pass, P1_pass, owner} !== 4'b0000) begin miscompares++; $display("FAIL rr_idle_between: got %b want 0000", {P0_pass, P1_pass, owner}); end
        tick();
        vectors++; if ({P0_pass, P1_pass, owner} !== 4'b0110) begin miscompares++; $display("FAIL rr_second_tie: got %b want 0110", {P0_pass, P1_pass, owner}); end
        do_release(1, 0, 32'h0);
        tick();
        vectors++; if ({P0_pass, P1_pass, owner} !== 4'b1001) begin miscompares++; $display("FAIL rr_third: got %b want 1001", {P0_pass, P1_pass, owner}); end
        do_release(0, 0, 32'h0);
    endtask

    task automatic test_sc_broken;
        do_grant(0);
        do_trig(0, 1, 2'b01, 32'h100);
        vectors++; if ({P0_success, RSV_valid} !== 3'b101) begin miscompares++; $display("FAIL ll_p0: got %b want 101", {P0_success, RSV_valid}); end
        do_release(0, 0, 32'h100);
        do_grant(1);
        vectors++; if (P1_pass !== 1'b1) begin miscompares++; $display("FAIL p1_write_grant: got %b want 1", P1_pass); end
        do_release(1, 1, 32'h100);
        vectors++; if (RSV_valid !== 2'b00) begin miscompares++; $display("FAIL snoop_clear_p0: got %b want 00", RSV_valid); end
        do_grant(0);
        do_trig(0, 1, 2'b10, 32'h100);
        vectors++; if ({P0_success, RSV_valid[0]} !== 2'b00) begin miscompares++; $display("FAIL sc_broken: got %b want 00", {P0_success, RSV_valid[0]}); end
        do_release(0, 0, 32'h100);
    endtask

    task automatic test_sc_ok;
        do_grant(1);
        do_trig(1, 1, 2'b01, 32'h100);
        vectors++; if ({P1_success, RSV_valid} !== 3'b110) begin miscompares++; $display("FAIL ll_p1: got %b want 110", {P1_success, RSV_valid}); end
        do_release(1, 0, 32'h100);
        do_grant(0);
        do_trig(0, 1, 2'b01, 32'h100);
        vectors++; if (RSV_valid !== 2'b11) begin miscompares++; $display("FAIL both_rsv: got %b want 11", RSV_valid); end
        do_trig(0, 1, 2'b10, 32'h100);
        vectors++; if ({P0_success, RSV_valid} !== 3'b110) begin miscompares++; $display("FAIL sc_ok: got %b want 110", {P0_success, RSV_valid}); end
        do_release(0, 1, 32'h100);
        vectors++; if (RSV_valid !== 2'b00) begin miscompares++; $display("FAIL sc_write_clears_p1: got %b want 00", RSV_valid); end
        do_grant(1);
        do_trig(1, 1, 2'b01, 32'h104);
        do_release(1, 0, 32'h104);
        do_grant(0);
        do_trig(0, 1, 2'b01, 32'h100);
        do_trig(0, 1, 2'b10, 32'h100);
        do_release(0, 1, 32'h100);
        vectors++; if ({P0_success, RSV_valid} !== 3'b110) begin miscompares++; $display("FAIL p1_rsv_104_kept: got %b want 110", {P0_success, RSV_valid}); end
        do_grant(0);
        do_trig(0, 1, 2'b01, 32'h100);
        do_trig(0, 1, 2'b10, 32'h101);
        vectors++; if ({P0_success, RSV_valid[0]} !== 2'b00) begin miscompares++; $display("FAIL sc_addr_mismatch: got %b want 00", {P0_success, RSV_valid[0]}); end
        tick();
        vectors++; if (P0_success !== 1'b0) begin miscompares++; $display("FAIL success_hold: got %b want 0", P0_success); end
        do_trig(0, 0, 2'b10, 32'h100);
        vectors++; if ({P0_success, RSV_valid} !== 3'b110) begin miscompares++; $display("FAIL plain_trigger: got %b want 110", {P0_success, RSV_valid}); end
        do_release(0, 0, 32'h100);
    endtask

    task automatic test_foreign_trigger;
        do_grant(0);
        do_trig(1, 1, 2'b10, 32'h999);
        vectors++; if ({P1_success, RSV_valid, P0_pass} !== 4'b1101) begin miscompares++; $display("FAIL foreign_trigger: got %b want 1101", {P1_success, RSV_valid, P0_pass}); end
        do_release(0, 0, 32'h0);
    endtask

    task automatic test_trigger_with_complete;
        do_grant(0);
        do_trig(0, 1, 2'b10, 32'h300);
        vectors++; if (P0_success !== 1'b0) begin miscompares++; $display("FAIL pre_sc_fail: got %b want 0", P0_success); end
        trigger_P0 = 1; atomic_inst_P0 = 1; instr_type_P0 = 2'b01; MAR_P0 = 32'h300;
        P0_mem_complete = 1; req_P0 = 0;
        tick();
        trigger_P0 = 0; atomic_inst_P0 = 0; P0_mem_complete = 0;
        vectors++; if ({owner, P0_success, RSV_valid} !== 5'b00111) begin miscompares++; $display("FAIL trig_and_complete: got %b want 00111", {owner, P0_success, RSV_valid}); end
    endtask

    task automatic test_reset_mid_grant;
        do_grant(1);
        vectors++; if ({owner, RSV_valid} !== 4'b1011) begin miscompares++; $display("FAIL pre_reset_state: got %b want 1011", {owner, RSV_valid}); end
        reset = 1;
        tick();
        vectors++; if ({owner, RSV_valid, P0_pass, P1_pass} !== 6'b000000) begin miscompares++; $display("FAIL reset_mid_grant: got %b want 000000", {owner, RSV_valid, P0_pass, P1_pass}); end
        req_P1 = 0;
        reset = 0;
        tick();
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout;
        int held;
        req_P0 = 1; req_P1 = 1;
        tick();
        do_trig(0, 1, 2'b01, 32'h500);
        vectors++; if ({P0_pass, RSV_valid[0]} !== 2'b11) begin miscompares++; $display("FAIL wd_setup: got %b want 11", {P0_pass, RSV_valid[0]}); end
        held = 2;
        for (int i = 0; i < 300 && P0_pass; i++) begin
            tick();
            if (P0_pass) held++;
        end
        vectors++; if ({P0_pass, RSV_valid[0]} !== 2'b00) begin miscompares++; $display("FAIL wd_release: got %b want 00", {P0_pass, RSV_valid[0]}); end
        vectors++; if (held < 250 || held > 260) begin miscompares++; $display("FAIL wd_duration: got %0d want 250..260", held); end
        req_P0 = 0;
        tick();
        vectors++; if (P1_pass !== 1'b1) begin miscompares++; $display("FAIL wd_next_grant: got %b want 1", P1_pass); end
        do_release(1, 0, 32'h0);
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_sc_broken();
        test_sc_ok();
        test_foreign_trigger();
        test_trigger_with_complete();
        test_reset_mid_grant();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
